// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder controller.
// The state encoding is fixed here so the controller and any future observers agree on it.
package serial_add_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_DONE = 2'd2;

    localparam int WIDTH_MIN = 1;
    localparam int WIDTH_MAX = 64;

    function automatic bit is_accept_state(input state_t st);
        return (st == ST_IDLE) || (st == ST_DONE);
    endfunction

endpackage

// File: rtl/serial_add_ctrl_fa_cell.sv
// One-bit full adder; the only arithmetic cell of the serial adder.
// Purely combinational, with the carry taken from the generate/propagate terms.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    logic p;

    assign p    = a ^ b;
    assign sum  = p ^ cin;
    assign cout = (a & b) | (cin & p);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: adds two WIDTH-bit operands LSB first through one fa_cell,
// one bit per clock, with a start/busy/done handshake.
//
//   state   | meaning
//   --------+---------------------------------------------------------------
//   ST_IDLE | waiting for start; sum/cout hold the last result
//   ST_RUN  | one operand bit per cycle through the full adder (WIDTH cycles)
//   ST_DONE | one-cycle done pulse; start here is accepted back-to-back
//   2'd3    | unreachable; returns to ST_IDLE on the next edge
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           state;
    state_t           state_nxt;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] r_sh;
    logic [WIDTH-1:0] r_next;
    logic             c_ff;
    logic [CNT_W-1:0] cnt;

    logic             load;
    logic             shift;
    logic             last;

    logic             fa_s;
    logic             fa_co;

    fa_cell u_fa (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .cin  (c_ff),
        .sum  (fa_s),
        .cout (fa_co)
    );

    // The new sum bit enters at the MSB, so after WIDTH shifts bit 0 sits at the LSB.
    generate
        if (WIDTH == 1) begin : g_r_w1
            assign r_next = fa_s;
        end else begin : g_r_wn
            assign r_next = {fa_s, r_sh[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = ST_IDLE;
        case (state)
            ST_IDLE: state_nxt = start ? ST_RUN : ST_IDLE;
            ST_RUN:  state_nxt = (cnt == CNT_LAST) ? ST_DONE : ST_RUN;
            ST_DONE: state_nxt = start ? ST_RUN : ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy  = 1'b0;
        done  = 1'b0;
        load  = 1'b0;
        shift = 1'b0;
        last  = 1'b0;
        case (state)
            ST_IDLE: begin
                load = start;
            end
            ST_RUN: begin
                busy  = 1'b1;
                shift = 1'b1;
                last  = (cnt == CNT_LAST);
            end
            ST_DONE: begin
                done = 1'b1;
                load = start;
            end
            default: begin
                load = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh <= '0;
            b_sh <= '0;
            r_sh <= '0;
            c_ff <= 1'b0;
            cnt  <= '0;
            sum  <= '0;
            cout <= 1'b0;
        end else if (load) begin
            a_sh <= a;
            b_sh <= b;
            c_ff <= cin;
            r_sh <= '0;
            cnt  <= '0;
        end else if (shift) begin
            a_sh <= a_sh >> 1;
            b_sh <= b_sh >> 1;
            c_ff <= fa_co;
            r_sh <= r_next;
            cnt  <= cnt + CNT_W'(1);
            // Result registers only move on the RUN->DONE edge, so they stay stable while busy.
            if (last) begin
                sum  <= r_next;
                cout <= fa_co;
            end
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl: a vector table at WIDTH=8 plus handshake corner
// sequences, and an exhaustive pass over a WIDTH=1 instance.
module tb_serial_add_ctrl;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start, cin;
    logic [7:0] a, b;
    logic       busy, done, cout;
    logic [7:0] sum;

    logic       rst1, start1, cin1;
    logic [0:0] a1, b1;
    logic       busy1, done1, cout1;
    logic [0:0] sum1;

    serial_add_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .sum(sum), .cout(cout)
    );

    serial_add_ctrl #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst1), .start(start1), .a(a1), .b(b1), .cin(cin1),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] held_sum;
    logic       held_cout;

    typedef struct {
        logic [7:0] va;
        logic [7:0] vb;
        logic       vc;
        logic [7:0] es;
        logic       ec;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one add, optionally scrambling operands and start while busy, and checks timing and result.
    task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_, input logic tc,
                          input logic [7:0] es, input logic ec, input bit scramble,
                          input string name);
        int  lat;
        bit  seen;
        a = ta; b = tb_; cin = tc; start = 1'b1;
        tick();
        start = 1'b0;
        lat   = 0;
        seen  = 0;
        check({name, " busy after accept"}, 64'(busy), 64'd1);
        for (int i = 0; i < 20 && !seen; i++) begin
            if (busy) begin
                check({name, " sum held while busy"}, 64'({cout, sum}), 64'({held_cout, held_sum}));
            end
            if (scramble) begin
                a     = 8'($urandom);
                b     = 8'($urandom);
                cin   = 1'($urandom);
                start = 1'($urandom);
            end
            tick();
            lat++;
            if (done) begin
                seen  = 1;
                start = 1'b0;
            end
        end
        check({name, " done seen"}, 64'(seen), 64'd1);
        check({name, " latency"}, 64'(lat), 64'd8);
        check({name, " sum"}, 64'(sum), 64'(es));
        check({name, " cout"}, 64'(cout), 64'(ec));
        held_sum  = es;
        held_cout = ec;
        tick();
        check({name, " done one cycle"}, 64'({busy, done}), 64'd0);
    endtask

    initial begin
        vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        vecs[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
        vecs[4] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
        vecs[5] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
        vecs[6] = '{8'h12, 8'h34, 1'b1, 8'h47, 1'b0};
        vecs[7] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1};

        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        rst1 = 1'b1; start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
        held_sum = '0; held_cout = 1'b0;
        tick();
        tick();
        check("reset w8 outputs", 64'({busy, done, cout, sum}), 64'd0);
        check("reset w1 outputs", 64'({busy1, done1, cout1, sum1}), 64'd0);
        rst = 1'b0; rst1 = 1'b0;
        tick();
        check("idle no start", 64'({busy, done}), 64'd0);

        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].va, vecs[i].vb, vecs[i].vc, vecs[i].es, vecs[i].ec, 1'b0,
                   $sformatf("vec%0d", i));
        end

        // Operands and start toggle during RUN; only the accept-cycle values count.
        run_op(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1, "scramble");
        run_op(8'hC3, 8'h4E, 1'b1, 8'h12, 1'b1, 1'b1, "scramble2");

        // Back-to-back with start held high.
        begin
            int  lat;
            bit  seen;
            a = 8'h01; b = 8'h02; cin = 1'b0; start = 1'b1;
            tick();
            a = 8'h10; b = 8'h20;
            lat = 0; seen = 0;
            for (int i = 0; i < 20 && !seen; i++) begin
                tick();
                lat++;
                if (done) seen = 1;
            end
            check("b2b first latency", 64'(lat), 64'd8);
            check("b2b first sum", 64'({cout, sum}), 64'h003);
            lat = 0; seen = 0;
            for (int i = 0; i < 20 && !seen; i++) begin
                tick();
                lat++;
                if (done) seen = 1;
            end
            check("b2b done spacing", 64'(lat), 64'd9);
            check("b2b second sum", 64'({cout, sum}), 64'h030);
            start = 1'b0;
            tick();
            check("b2b return idle", 64'({busy, done}), 64'd0);
            held_sum = 8'h30; held_cout = 1'b0;
        end

        // Reset on the 4th RUN cycle abandons the add without a done pulse.
        begin
            bit any_done;
            a = 8'h5A; b = 8'h3C; cin = 1'b0; start = 1'b1;
            tick();
            start = 1'b0;
            tick();
            tick();
            tick();
            check("pre-reset busy", 64'(busy), 64'd1);
            rst = 1'b1;
            tick();
            check("mid-run reset outputs", 64'({busy, done, cout, sum}), 64'd0);
            rst = 1'b0;
            any_done = 0;
            for (int i = 0; i < 10; i++) begin
                tick();
                if (done || busy) any_done = 1;
            end
            check("no activity after reset", 64'(any_done), 64'd0);
            held_sum = 8'h00; held_cout = 1'b0;
            run_op(8'h07, 8'h01, 1'b0, 8'h08, 1'b0, 1'b0, "post-reset");
        end

        // WIDTH=1: exhaustive operands, done two cycles after the accept edge's cycle.
        for (int k = 0; k < 8; k++) begin
            logic [2:0] v;
            v = 3'(k);
            a1 = v[2]; b1 = v[1]; cin1 = v[0]; start1 = 1'b1;
            tick();
            start1 = 1'b0;
            check($sformatf("w1 combo%0d busy", k), 64'({busy1, done1}), 64'b10);
            tick();
            check($sformatf("w1 combo%0d done", k), 64'({busy1, done1}), 64'b01);
            check($sformatf("w1 combo%0d result", k), 64'({cout1, sum1}),
                  64'(v[2]) + 64'(v[1]) + 64'(v[0]));
            tick();
            check($sformatf("w1 combo%0d idle", k), 64'({busy1, done1}), 64'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
